bin_to_bcd_seq: RTL and testbench

// Sequential binary-to-digit converter feeding the 4-digit 7-segment display driver.

---
 rtl/bin_to_bcd_seq_if.sv | 27 ++
 rtl/bin_to_bcd_seq.sv | 119 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between the ALU-side requester and the
// binary-to-digit converter feeding the 7-segment display driver.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] value;
   logic             is_signed;
   logic             hex_mode;
   logic             busy;
   logic             done;
   logic             neg;
   logic [3:0]       d0;
   logic [3:0]       d1;
   logic [3:0]       d2;
   logic [3:0]       d3;

   modport master (
      output start, value, is_signed, hex_mode,
      input  busy, done, neg, d0, d1, d2, d3
   );

   modport slave (
      input  start, value, is_signed, hex_mode,
      output busy, done, neg, d0, d1, d2, d3
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-digit converter: iterative double-dabble BCD or hex
// passthrough, with digits updated only on completion.
module bin_to_bcd_seq #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   bin_to_bcd_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] mag_r;
   logic [15:0]      bcd_r;
   logic [CW-1:0]    cnt_r;
   logic             neg_pending_r;
   logic             busy_r;
   logic             done_r;
   logic             neg_r;
   logic [15:0]      digits_r;

   logic             neg_in_s;
   logic [WIDTH-1:0] mag_s;
   logic [15:0]      bcd_adj_s;
   logic [15:0]      bcd_next_s;
   logic             last_iter_s;

   // Add 3 to every BCD nibble that is 5 or more before the next shift.
   function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
      logic [15:0] res;
      res = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end else begin
            res[4*i +: 4] = bcd[4*i +: 4];
         end
      end
      return res;
   endfunction

   // Operand magnitude and next double-dabble step. Negating in WIDTH bits
   // already gives the right unsigned magnitude for the most negative value.
   always_comb begin
      neg_in_s = bus.is_signed & bus.value[WIDTH-1];
      if (neg_in_s) begin
         mag_s = ~bus.value + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag_s = bus.value;
      end
      bcd_adj_s   = dabble_adjust(bcd_r);
      bcd_next_s  = {bcd_adj_s[14:0], mag_r[WIDTH-1]};
      last_iter_s = (cnt_r == CW'(WIDTH - 1));
   end

   // Conversion FSM with registered handshake and digit outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         mag_r         <= '0;
         bcd_r         <= 16'h0000;
         cnt_r         <= '0;
         neg_pending_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         neg_r         <= 1'b0;
         digits_r      <= 16'h0000;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  if (bus.hex_mode) begin
                     digits_r <= 16'(bus.value);
                     neg_r    <= 1'b0;
                     done_r   <= 1'b1;
                  end else begin
                     mag_r         <= mag_s;
                     neg_pending_r <= neg_in_s;
                     bcd_r         <= 16'h0000;
                     cnt_r         <= '0;
                     busy_r        <= 1'b1;
                     state_r       <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               bcd_r <= bcd_next_s;
               mag_r <= {mag_r[WIDTH-2:0], 1'b0};
               cnt_r <= cnt_r + CW'(1);
               if (last_iter_s) begin
                  digits_r <= bcd_next_s;
                  neg_r    <= neg_pending_r;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.neg  = neg_r;
   assign bus.d0   = digits_r[3:0];
   assign bus.d1   = digits_r[7:4];
   assign bus.d2   = digits_r[11:8];
   assign bus.d3   = digits_r[15:12];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed scenarios plus random
// operands compared with an arithmetic reference model.
module tb_bin_to_bcd_seq;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   bin_to_bcd_seq_if #(.WIDTH(8)) bus();

   bin_to_bcd_seq #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {neg, d3, d2, d1, d0} from plain integer arithmetic.
   function automatic logic [16:0] model(input logic [7:0] v, input bit s, input bit h);
      int n;
      int m;
      if (h) return {1'b0, 8'h00, v};
      n = (s && v > 8'd127) ? int'(v) - 256 : int'(v);
      m = (n < 0) ? -n : n;
      return {(n < 0), 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   function automatic logic [16:0] observed();
      return {bus.neg, bus.d3, bus.d2, bus.d1, bus.d0};
   endfunction

   // Drives one request (caller is at a negedge) and waits for done; no checking.
   task automatic run_conv(input logic [7:0] v, input bit s, input bit h,
                           output int lat, output logic [16:0] obs,
                           output bit overlap, output bit busy_seen);
      bus.value     = v;
      bus.is_signed = s;
      bus.hex_mode  = h;
      bus.start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat       = 0;
      overlap   = bus.busy && bus.done;
      busy_seen = bus.busy;
      while (!bus.done && lat < 30) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_seen = 1'b1;
         if (bus.busy && bus.done) overlap = 1'b1;
      end
      obs = observed();
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.value     = 8'h00;
      bus.is_signed = 1'b0;
      bus.hex_mode  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, observed()} !== 19'h0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0", {bus.busy, bus.done, observed()});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      int lat; logic [16:0] obs; bit ov; bit bs;
      run_conv(8'hFF, 1'b0, 1'b0, lat, obs, ov, bs);
      checks++;
      if (obs !== 17'h00255) begin
         errors++; $display("FAIL unsigned_255: got %h expected 00255", obs);
      end
      checks++;
      if (lat !== 8 || ov || !bs) begin
         errors++; $display("FAIL unsigned_timing: lat=%0d overlap=%0b busy=%0b expected 8/0/1", lat, ov, bs);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL done_pulse_width: done=%b expected 0", bus.done);
      end
   endtask

   task automatic test_signed();
      logic [7:0] vals [3] = '{8'h80, 8'hF6, 8'h7F};
      logic [16:0] exp_v [3] = '{17'h10128, 17'h10010, 17'h00127};
      int lat; logic [16:0] obs; bit ov; bit bs;
      for (int i = 0; i < 3; i++) begin
         run_conv(vals[i], 1'b1, 1'b0, lat, obs, ov, bs);
         checks++;
         if (obs !== exp_v[i] || obs !== model(vals[i], 1'b1, 1'b0) || lat !== 8) begin
            errors++;
            $display("FAIL signed_%h: got %h lat=%0d expected %h lat=8", vals[i], obs, lat, exp_v[i]);
         end
      end
   endtask

   task automatic test_hex();
      int lat; logic [16:0] obs; bit ov; bit bs;
      run_conv(8'hA7, 1'b1, 1'b1, lat, obs, ov, bs);
      checks++;
      if (obs !== 17'h000A7 || lat !== 0 || bs) begin
         errors++;
         $display("FAIL hex_a7: got %h lat=%0d busy=%0b expected 000a7 lat=0 busy=0", obs, lat, bs);
      end
   endtask

   task automatic test_ignore_start();
      logic [16:0] prev;
      int dones; int done_at; bit unstable;
      logic [16:0] res;
      prev = observed();
      bus.value = 8'd42; bus.is_signed = 1'b0; bus.hex_mode = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; bus.value = 8'd99;
      dones = 0; done_at = -1; unstable = 1'b0; res = '0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (bus.done) begin
            dones++; done_at = c; res = observed();
         end else if (bus.busy && observed() !== prev) begin
            unstable = 1'b1;
         end
         bus.start = (c == 3 || c == 5);
      end
      bus.start = 1'b0;
      checks++;
      if (dones !== 1 || done_at !== 8) begin
         errors++; $display("FAIL ignore_start_done: pulses=%0d at=%0d expected 1 at 8", dones, done_at);
      end
      checks++;
      if (res !== model(8'd42, 1'b0, 1'b0) || unstable) begin
         errors++; $display("FAIL ignore_start_result: got %h unstable=%0b expected 00042 stable", res, unstable);
      end
   endtask

   task automatic test_reset_abort();
      bit saw_done;
      int lat; logic [16:0] obs; bit ov; bit bs;
      bus.value = 8'd200; bus.is_signed = 1'b0; bus.hex_mode = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, observed()} !== 19'h0) begin
         errors++; $display("FAIL reset_abort: got %h expected 0", {bus.busy, bus.done, observed()});
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++; $display("FAIL reset_no_done: activity after abort, expected none");
      end
      run_conv(8'd0, 1'b1, 1'b0, lat, obs, ov, bs);
      checks++;
      if (obs !== 17'h00000 || lat !== 8) begin
         errors++; $display("FAIL zero_after_reset: got %h lat=%0d expected 00000 lat=8", obs, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat1; int lat2; logic [16:0] o1; logic [16:0] o2; bit ov; bit bs;
      run_conv(8'd1, 1'b0, 1'b0, lat1, o1, ov, bs);
      run_conv(8'd100, 1'b0, 1'b0, lat2, o2, ov, bs);
      checks++;
      if (o1 !== 17'h00001 || o2 !== 17'h00100) begin
         errors++; $display("FAIL b2b_result: got %h,%h expected 00001,00100", o1, o2);
      end
      checks++;
      if (lat1 !== 8 || lat2 !== 8) begin
         errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 8,8", lat1, lat2);
      end
   endtask

   task automatic test_random();
      int lat; logic [16:0] obs; bit ov; bit bs;
      logic [7:0] v; bit s; bit h;
      for (int i = 0; i < 40; i++) begin
         v = 8'($urandom);
         s = 1'($urandom);
         h = ($urandom_range(0, 3) == 0);
         run_conv(v, s, h, lat, obs, ov, bs);
         checks++;
         if (obs !== model(v, s, h) || lat !== (h ? 0 : 8) || ov || (bs === h)) begin
            errors++;
            $display("FAIL random_%0d v=%h s=%0b h=%0b: got %h lat=%0d ov=%0b busy=%0b expected %h lat=%0d",
                     i, v, s, h, obs, lat, ov, bs, model(v, s, h), h ? 0 : 8);
         end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_hex();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
